// File: rtl/alu_exec_pkg.sv
//------------------------------------------------------------------------------
// alu_exec_pkg : opcodes, FSM states, instruction field positions and sign-extend
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package alu_exec_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd5;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 25;
    localparam int RS_LSB  = 22;
    localparam int RT_LSB  = 19;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        MEM  = 2'd3
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/exec_regfile.sv
//------------------------------------------------------------------------------
// exec_regfile : NREG x DW register file, 2 async read ports, 1 sync write, R0 = 0
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module exec_regfile #(
    parameter int NREG = 8,
    parameter int DW   = 32,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_raddr_a,
    output logic [DW-1:0] o_rdata_a,
    input  logic [AW-1:0] i_raddr_b,
    output logic [DW-1:0] o_rdata_b,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] w_regs [NREG];

    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        if (gi == 0) begin : g_zero
            assign w_regs[gi] = '0;
        end else begin : g_store
            logic [DW-1:0] r_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (i_we && (i_waddr == AW'(gi))) begin
                    r_q <= i_wdata;
                end
            end
            assign w_regs[gi] = r_q;
        end
    end

    assign o_rdata_a = w_regs[i_raddr_a];
    assign o_rdata_b = w_regs[i_raddr_b];

endmodule

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
//------------------------------------------------------------------------------
// alu_exec_ctrl : multi-cycle execute controller driving an external ALU and a
//                 request/ack data memory port; all outputs registered.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_exec_ctrl
    import alu_exec_pkg::*;
#(
    parameter int NREG = 8,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [31:0]   instr,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_fun,
    input  logic [DW-1:0] alu_valE,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          retire,
    output logic          illegal,
    output logic          busy
);

    localparam int AW = $clog2(NREG);

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_op, w_op_nxt;
    logic [AW-1:0] r_rd, w_rd_nxt;
    logic [DW-1:0] r_result, w_result_nxt;
    logic [DW-1:0] r_alu_a, w_alu_a_nxt;
    logic [DW-1:0] r_alu_b, w_alu_b_nxt;
    logic [3:0]    r_alu_fun, w_alu_fun_nxt;
    logic          r_mem_req, w_mem_req_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [DW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_retire, w_retire_nxt;
    logic          r_illegal, w_illegal_nxt;
    logic          r_ready, r_busy;

    logic [3:0]    w_op;
    logic [AW-1:0] w_rd, w_rs, w_rt;
    logic [15:0]   w_imm;
    logic          w_legal, w_memop, w_accept;
    logic [DW-1:0] w_rs_data, w_rt_data;
    logic          w_rf_we;
    logic [DW-1:0] w_rf_wdata;
    logic          w_unused;

    assign w_op     = instr[OP_LSB +: 4];
    assign w_rd     = instr[RD_LSB +: AW];
    assign w_rs     = instr[RS_LSB +: AW];
    assign w_rt     = instr[RT_LSB +: AW];
    assign w_imm    = instr[IMM_LSB +: 16];
    assign w_legal  = (w_op <= OP_SW);
    assign w_memop  = (w_op == OP_LW) || (w_op == OP_SW);
    assign w_accept = instr_valid && r_ready;
    assign w_unused = ^instr[18:16];

    exec_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_raddr_a (w_rs),
        .o_rdata_a (w_rs_data),
        .i_raddr_b (w_rt),
        .o_rdata_b (w_rt_data),
        .i_we      (w_rf_we),
        .i_waddr   (r_rd),
        .i_wdata   (w_rf_wdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= OP_ADD;
            r_rd        <= '0;
            r_result    <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_fun   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_retire    <= 1'b0;
            r_illegal   <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_rd        <= w_rd_nxt;
            r_result    <= w_result_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_fun   <= w_alu_fun_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_retire    <= w_retire_nxt;
            r_illegal   <= w_illegal_nxt;
            r_ready     <= (w_state_nxt == IDLE);
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_rd_nxt        = r_rd;
        w_result_nxt    = r_result;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_fun_nxt   = r_alu_fun;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_retire_nxt    = 1'b0;
        w_illegal_nxt   = 1'b0;
        w_rf_we         = 1'b0;
        w_rf_wdata      = r_result;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_legal) begin
                        w_op_nxt    = w_op;
                        w_rd_nxt    = w_rd;
                        w_alu_b_nxt = w_rt_data;
                        if (w_memop) begin
                            // Address = sign-extended offset + base register
                            w_alu_a_nxt   = sext16(w_imm);
                            w_alu_fun_nxt = OP_ADD;
                            if (w_op == OP_SW) begin
                                w_mem_wdata_nxt = w_rs_data;
                            end
                        end else begin
                            w_alu_a_nxt   = w_rs_data;
                            w_alu_fun_nxt = w_op;
                        end
                        w_state_nxt = EXEC;
                    end else begin
                        w_illegal_nxt = 1'b1;
                    end
                end
            end
            EXEC: begin
                w_result_nxt = alu_valE;
                if ((r_op == OP_LW) || (r_op == OP_SW)) begin
                    w_mem_addr_nxt = alu_valE;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_we_nxt   = (r_op == OP_SW);
                    w_state_nxt    = MEM;
                end else begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                w_rf_we      = 1'b1;
                w_rf_wdata   = r_result;
                w_retire_nxt = 1'b1;
                w_state_nxt  = IDLE;
            end
            MEM: begin
                if (mem_ack) begin
                    w_rf_we       = (r_op == OP_LW);
                    w_rf_wdata    = mem_rdata;
                    w_mem_req_nxt = 1'b0;
                    w_retire_nxt  = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign instr_ready = r_ready;
    assign busy        = r_busy;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_fun     = r_alu_fun;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign retire      = r_retire;
    assign illegal     = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
//------------------------------------------------------------------------------
// tb_alu_exec_ctrl : directed self-checking bench for alu_exec_ctrl
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_ctrl;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_fun;
    logic [31:0] alu_valE;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        retire;
    logic        illegal;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;

    alu_exec_ctrl #(.NREG(8), .DW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_fun     (alu_fun),
        .alu_valE    (alu_valE),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .retire      (retire),
        .illegal     (illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External combinational ALU
    always_comb begin
        case (alu_fun)
            4'd0:    alu_valE = alu_a + alu_b;
            4'd1:    alu_valE = alu_a - alu_b;
            4'd2:    alu_valE = alu_a & alu_b;
            4'd3:    alu_valE = alu_a ^ alu_b;
            default: alu_valE = 32'hDEAD_0000;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs, input logic [2:0] rt,
                                       input logic [15:0] imm);
        return {op, rd, rs, rt, 3'b000, imm};
    endfunction

    task automatic issue(input logic [31:0] w);
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic run_alu(input string tag, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt,
                           input logic [31:0] ea, input logic [31:0] eb);
        issue(mk(op, rd, rs, rt, 16'h0000));
        check({tag, ".a"},     alu_a, ea);
        check({tag, ".b"},     alu_b, eb);
        check({tag, ".fun"},   {28'd0, alu_fun}, {28'd0, op});
        check({tag, ".busy"},  {31'd0, busy}, 32'd1);
        check({tag, ".rdy0"},  {31'd0, instr_ready}, 32'd0);
        check({tag, ".ret_e"}, {31'd0, retire}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".ret_w"}, {31'd0, retire}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".ret"},   {31'd0, retire}, 32'd1);
        check({tag, ".rdy1"},  {31'd0, instr_ready}, 32'd1);
    endtask

    // Reads R[k] by issuing ADD r0, rk, r0 and observing the operand A register
    task automatic read_reg(input logic [2:0] k, input logic [31:0] exp);
        run_alu($sformatf("rd_r%0d", k), 4'd0, 3'd0, k, 3'd0, exp, 32'd0);
    endtask

    task automatic run_mem(input string tag, input logic [3:0] op, input logic [2:0] rd,
                           input logic [2:0] rs, input logic [2:0] rt, input logic [15:0] imm,
                           input logic [31:0] ea, input logic [31:0] eb,
                           input int waitn, input logic [31:0] rdata,
                           input logic [31:0] eaddr, input logic [31:0] ewdata);
        logic is_sw;
        is_sw = (op == 4'd5);
        issue(mk(op, rd, rs, rt, imm));
        check({tag, ".a"},   alu_a, ea);
        check({tag, ".b"},   alu_b, eb);
        check({tag, ".fun"}, {28'd0, alu_fun}, 32'd0);
        @(posedge clk); #1;
        check({tag, ".req"},  {31'd0, mem_req}, 32'd1);
        check({tag, ".addr"}, mem_addr, eaddr);
        check({tag, ".we"},   {31'd0, mem_we}, {31'd0, is_sw});
        if (is_sw) check({tag, ".wdata"}, mem_wdata, ewdata);
        for (int i = 0; i < waitn; i++) begin
            @(posedge clk); #1;
            check({tag, ".hreq"},  {31'd0, mem_req}, 32'd1);
            check({tag, ".haddr"}, mem_addr, eaddr);
            check({tag, ".hwe"},   {31'd0, mem_we}, {31'd0, is_sw});
            if (is_sw) check({tag, ".hwdata"}, mem_wdata, ewdata);
            check({tag, ".hret"},  {31'd0, retire}, 32'd0);
        end
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        check({tag, ".req0"}, {31'd0, mem_req}, 32'd0);
        check({tag, ".ret"},  {31'd0, retire}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        #12;
        check("rst.ready", {31'd0, instr_ready}, 32'd1);
        check("rst.busy",  {31'd0, busy}, 32'd0);
        check("rst.req",   {31'd0, mem_req}, 32'd0);
        check("rst.a",     alu_a, 32'd0);
        check("rst.fun",   {28'd0, alu_fun}, 32'd0);
        check("rst.ret",   {31'd0, retire}, 32'd0);
        check("rst.ill",   {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // No valid, stray ack: nothing should start
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle.busy", {31'd0, busy}, 32'd0);
            check("idle.ret",  {31'd0, retire}, 32'd0);
            check("idle.req",  {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        run_mem("lw_r1", 4'd4, 3'd1, 3'd0, 3'd0, 16'h0020, 32'h20, 32'h0, 1, 32'd5, 32'h20, 32'h0);
        run_mem("lw_r2", 4'd4, 3'd2, 3'd0, 3'd0, 16'h0024, 32'h24, 32'h0, 0, 32'd3, 32'h24, 32'h0);

        run_alu("add", 4'd0, 3'd3, 3'd1, 3'd2, 32'd5, 32'd3);
        read_reg(3'd3, 32'd8);
        run_alu("sub", 4'd1, 3'd4, 3'd2, 3'd1, 32'd3, 32'd5);
        read_reg(3'd4, 32'hFFFF_FFFE);
        run_alu("xor", 4'd3, 3'd5, 3'd1, 3'd1, 32'd5, 32'd5);
        read_reg(3'd5, 32'd0);
        run_alu("and", 4'd2, 3'd6, 3'd1, 3'd2, 32'd5, 32'd3);
        read_reg(3'd6, 32'd1);

        run_mem("lw_base", 4'd4, 3'd2, 3'd0, 3'd0, 16'h0000, 32'h0, 32'h0, 0, 32'h100, 32'h0, 32'h0);
        run_mem("sw", 4'd5, 3'd0, 3'd1, 3'd2, 16'hFFFC, 32'hFFFF_FFFC, 32'h100, 4, 32'h0,
                32'h0000_00FC, 32'd5);
        run_mem("lw_r7", 4'd4, 3'd7, 3'd0, 3'd0, 16'h0010, 32'h10, 32'h0, 0, 32'hDEAD_BEEF,
                32'h10, 32'h0);
        read_reg(3'd7, 32'hDEAD_BEEF);

        run_alu("add_r0", 4'd0, 3'd0, 3'd1, 3'd2, 32'd5, 32'h100);
        read_reg(3'd0, 32'd0);

        run_mem("lw_max", 4'd4, 3'd1, 3'd0, 3'd0, 16'h0030, 32'h30, 32'h0, 2, 32'h7FFF_FFFF,
                32'h30, 32'h0);
        run_mem("lw_one", 4'd4, 3'd2, 3'd0, 3'd0, 16'h0034, 32'h34, 32'h0, 0, 32'd1, 32'h34, 32'h0);
        run_alu("wrap_add", 4'd0, 3'd3, 3'd1, 3'd2, 32'h7FFF_FFFF, 32'd1);
        read_reg(3'd3, 32'h8000_0000);

        // Undefined opcode: one pulse, nothing else moves
        issue(mk(4'd9, 3'd6, 3'd1, 3'd2, 16'h0000));
        check("ill.pulse", {31'd0, illegal}, 32'd1);
        check("ill.ret",   {31'd0, retire}, 32'd0);
        check("ill.ready", {31'd0, instr_ready}, 32'd1);
        check("ill.busy",  {31'd0, busy}, 32'd0);
        check("ill.a",     alu_a, 32'h8000_0000);
        check("ill.b",     alu_b, 32'h0);
        @(posedge clk); #1;
        check("ill.once",  {31'd0, illegal}, 32'd0);
        check("ill.ret2",  {31'd0, retire}, 32'd0);
        read_reg(3'd6, 32'd1);

        run_alu("wrap_sub", 4'd1, 3'd4, 3'd0, 3'd2, 32'd0, 32'd1);
        read_reg(3'd4, 32'hFFFF_FFFF);

        // Asynchronous reset while a load waits for its ack
        issue(mk(4'd4, 3'd5, 3'd0, 3'd0, 16'h0040));
        @(posedge clk); #1;
        check("ar.req1", {31'd0, mem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar.req0",  {31'd0, mem_req}, 32'd0);
        check("ar.busy",  {31'd0, busy}, 32'd0);
        check("ar.ready", {31'd0, instr_ready}, 32'd1);
        check("ar.ret",   {31'd0, retire}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ar.idle",  {31'd0, busy}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            read_reg(3'(k), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
